// File: rtl/addr_stepper.sv
// addr_stepper: 8-bit browse address sequencer, auto-steps at 3 rates
// ports: clk, rst_n, status[1:0], step_req -> addr[7:0], step_pulse, wrap, running
module addr_stepper #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SLOW_DIV = 100_000_000,
  parameter int unsigned MED_DIV  = 25_000_000,
  parameter int unsigned FAST_DIV = 6_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] status,
  input  logic       step_req,
  output logic [7:0] addr,
  output logic       step_pulse,
  output logic       wrap,
  output logic       running
);

  if (CLK_FREQ == 0 || SLOW_DIV < 2 ||
      MED_DIV < 2 || FAST_DIV < 2) begin : g_bad_param
    $error("addr_stepper: bad parameter");
  end

  localparam logic [31:0] SLOW_M1 = 32'(SLOW_DIV - 1);
  localparam logic [31:0] MED_M1  = 32'(MED_DIV - 1);
  localparam logic [31:0] FAST_M1 = 32'(FAST_DIV - 1);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  status_q;
  logic [31:0] presc_q, presc_d;
  logic [31:0] div_m1;
  logic        chg;
  logic        auto_step;
  logic        man_step;
  logic        step;

  always_comb begin
    div_m1 = SLOW_M1;
    unique case (status)
      2'b10:   div_m1 = MED_M1;
      2'b11:   div_m1 = FAST_M1;
      default: div_m1 = SLOW_M1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    auto_step = 1'b0;
    man_step  = 1'b0;
    chg       = (status != status_q);
    unique case (state_q)
      PAUSE: begin
        presc_d  = '0;
        man_step = step_req && !chg &&
                   (status == 2'b00) &&
                   (status_q == 2'b00);
        if (status != 2'b00)
          state_d = RUN;
      end
      RUN: begin
        // any status edge restarts the period
        if (chg) begin
          presc_d = '0;
        end else if (presc_q == div_m1) begin
          presc_d   = '0;
          auto_step = 1'b1;
        end else begin
          presc_d = presc_q + 32'd1;
        end
        if (status == 2'b00)
          state_d = PAUSE;
      end
      default: state_d = PAUSE;
    endcase
  end

  assign step = auto_step | man_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PAUSE;
      status_q   <= 2'b00;
      presc_q    <= '0;
      addr       <= 8'h00;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status;
      presc_q    <= presc_d;
      step_pulse <= step;
      wrap       <= step && (addr == 8'hFF);
      if (step)
        addr <= addr + 8'd1;
    end
  end

  assign running = (state_q == RUN);

endmodule

// File: tb/tb_addr_stepper.sv
// tb_addr_stepper: directed vectors for addr_stepper
// SLOW_DIV=8, MED_DIV=4, FAST_DIV=2
module tb_addr_stepper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] status;
  logic       step_req;
  logic [7:0] addr;
  logic       step_pulse;
  logic       wrap;
  logic       running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] status;
    logic       req;
    logic [7:0] addr;
    logic       pulse;
    logic       wrap;
    logic       run;
  } vec_t;

  vec_t tbl[23];

  always #5 clk = ~clk;

  addr_stepper #(
    .CLK_FREQ(100_000_000),
    .SLOW_DIV(8),
    .MED_DIV (4),
    .FAST_DIV(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .status    (status),
    .step_req  (step_req),
    .addr      (addr),
    .step_pulse(step_pulse),
    .wrap      (wrap),
    .running   (running)
  );

  task automatic chk8(input string name,
                      input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b",
               name, act, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] s,
                     input logic r);
    status   = s;
    step_req = r;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] s,
                              input logic r,
                              input logic [7:0] a,
                              input logic p,
                              input logic w,
                              input logic u);
    vec_t v;
    v.status = s;
    v.req    = r;
    v.addr   = a;
    v.pulse  = p;
    v.wrap   = w;
    v.run    = u;
    return v;
  endfunction

  initial begin
    logic [7:0] ea;
    logic       ep;
    logic       ew;

    // manual steps from 05, then RUN ignores step_req
    tbl[0]  = mk(2'd0, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(2'd0, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(2'd0, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(2'd0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(2'd0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(2'd0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(2'd0, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(2'd0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(2'd1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(2'd1, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(2'd1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(2'd0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(2'd0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0);
    // step_req on the 00->01 edge is dropped
    tbl[13] = mk(2'd1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b1);
    tbl[14] = mk(2'd1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1);
    tbl[15] = mk(2'd1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1);
    tbl[16] = mk(2'd1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1);
    tbl[17] = mk(2'd1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1);
    tbl[18] = mk(2'd1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1);
    tbl[19] = mk(2'd1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1);
    tbl[20] = mk(2'd1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1);
    tbl[21] = mk(2'd1, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b1);
    tbl[22] = mk(2'd0, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0);

    status   = 2'd0;
    step_req = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk8("rst_addr", addr, 8'h00);
    chk1("rst_pulse", step_pulse, 1'b0);
    chk1("rst_wrap", wrap, 1'b0);
    chk1("rst_run", running, 1'b0);
    rst_n = 1'b1;

    // hold paused
    for (int i = 1; i <= 20; i++) begin
      cyc(2'd0, 1'b0);
      chk8("hold_addr", addr, 8'h00);
      chk1("hold_pulse", step_pulse, 1'b0);
      chk1("hold_run", running, 1'b0);
    end

    // slow run from cycle 0
    for (int n = 1; n <= 25; n++) begin
      cyc(2'd1, 1'b0);
      ea = (n >= 25) ? 8'h03 :
           (n >= 17) ? 8'h02 :
           (n >= 9)  ? 8'h01 : 8'h00;
      ep = (n == 9) || (n == 17) || (n == 25);
      chk8($sformatf("slow%0d_addr", n), addr, ea);
      chk1($sformatf("slow%0d_pulse", n), step_pulse, ep);
      chk1($sformatf("slow%0d_run", n), running, 1'b1);
    end

    // fast, then switch to medium
    for (int k = 1; k <= 6; k++) begin
      cyc(2'd3, 1'b0);
      ep = (k == 3) || (k == 5);
      chk1($sformatf("fast%0d_pulse", k), step_pulse, ep);
    end
    chk8("fast_addr", addr, 8'h05);
    for (int k = 1; k <= 13; k++) begin
      cyc(2'd2, 1'b0);
      ep = (k == 5) || (k == 9) || (k == 13);
      ea = 8'h05 + 8'(k >= 5) + 8'(k >= 9) + 8'(k >= 13);
      chk8($sformatf("med%0d_addr", k), addr, ea);
      chk1($sformatf("med%0d_pulse", k), step_pulse, ep);
    end

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk8("arst_addr", addr, 8'h00);
    chk1("arst_pulse", step_pulse, 1'b0);
    chk1("arst_run", running, 1'b0);
    @(posedge clk);
    #1;
    status   = 2'd0;
    step_req = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 5; i++) cyc(2'd0, 1'b1);
    cyc(2'd0, 1'b0);
    chk8("pre5_addr", addr, 8'h05);

    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].status, tbl[i].req);
      chk8($sformatf("vec%0d_addr", i), addr, tbl[i].addr);
      chk1($sformatf("vec%0d_pulse", i), step_pulse, tbl[i].pulse);
      chk1($sformatf("vec%0d_wrap", i), wrap, tbl[i].wrap);
      chk1($sformatf("vec%0d_run", i), running, tbl[i].run);
    end

    // preload 7E, then fast through region edge and wrap
    for (int i = 0; i < 116; i++) cyc(2'd0, 1'b1);
    cyc(2'd0, 1'b0);
    chk8("pre7e_addr", addr, 8'h7E);
    for (int k = 1; k <= 262; k++) begin
      cyc(2'd3, 1'b0);
      ep = (k >= 3) && (k % 2 == 1);
      ea = (k < 3) ? 8'h7E : 8'(8'h7E + (k - 1) / 2);
      ew = (k == 261);
      chk8($sformatf("wrap%0d_addr", k), addr, ea);
      chk1($sformatf("wrap%0d_pulse", k), step_pulse, ep);
      chk1($sformatf("wrap%0d_wrap", k), wrap, ew);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
